// File: rtl/attn_result_streamer.sv
// Sweeps the 64x8 output tile grid out of BRAM and streams each tile as 16 row beats (first beat 1 cycle after VLD).
// Ping-pong buffer keeps one read in flight; TREADY low holds the beat stable and stalls reads once both buffers fill.
module attn_result_streamer #(
    parameter int D_W      = 16,
    parameter int TILE     = 16,
    parameter int LINE_NUM = 64,
    parameter int COL_NUM  = 8,
    parameter int OUT_W    = TILE * D_W
) (
    input  logic                        I_CLK,
    input  logic                        I_RST_N,
    input  logic                        I_ATTN_END,
    input  logic                        I_START,
    output logic                        O_RD_BRAM_EN,
    output logic [$clog2(LINE_NUM)-1:0] O_RD_BRAM_LINE,
    output logic [$clog2(COL_NUM)-1:0]  O_RD_BRAM_COL,
    input  logic                        I_BRAM_RD_VLD,
    input  logic [TILE*OUT_W-1:0]       I_BRAM_RD_MAT,
    output logic [OUT_W-1:0]            O_TDATA,
    output logic                        O_TVALID,
    input  logic                        I_TREADY,
    output logic                        O_TLAST,
    output logic [$clog2(LINE_NUM)-1:0] O_TILE_LINE,
    output logic [$clog2(COL_NUM)-1:0]  O_TILE_COL,
    output logic [$clog2(TILE)-1:0]     O_ROW,
    output logic                        O_BUSY,
    output logic                        O_DONE,
    output logic                        O_ABORT,
    output logic                        O_ERR
);
    localparam int LW    = $clog2(LINE_NUM);
    localparam int CW    = $clog2(COL_NUM);
    localparam int RW    = $clog2(TILE);
    localparam int TW    = LW + CW;
    localparam int TILES = LINE_NUM * COL_NUM;
    localparam int MAT_W = TILE * OUT_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [MAT_W-1:0]  r_buf [2];
    logic [1:0]        r_full, w_full_nxt;
    logic              r_wr_sel, r_rd_sel;
    logic [TW:0]       r_rd_cnt, w_rd_idx;
    logic [TW-1:0]     r_tile;
    logic [RW-1:0]     r_row, w_slot;
    logic              r_out, r_stale, r_err, r_abort, r_en;
    logic [LW-1:0]     r_line;
    logic [CW-1:0]     r_col;
    logic              w_start, w_abort, w_acc, w_last, w_tile_end, w_tvalid;
    logic              w_cap, w_spur, w_wr_tgt, w_tgt_free, w_issue, w_issue_any;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_acc       = 1'b0;
        case (r_state)
            S_IDLE: if (I_START && I_ATTN_END) begin
                w_state_nxt = S_RUN;
                w_start     = 1'b1;
            end
            S_RUN: if (!I_ATTN_END) begin
                w_abort     = 1'b1;
                w_state_nxt = S_IDLE;
            end else begin
                w_acc = w_tvalid && I_TREADY;
                if (w_acc && w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_tvalid   = r_full[r_rd_sel];
    assign w_last     = (r_tile == TW'(TILES - 1)) && (r_row == RW'(TILE - 1));
    assign w_tile_end = w_acc && (r_row == RW'(TILE - 1));
    assign w_cap      = I_BRAM_RD_VLD && r_out && (r_state == S_RUN) && !w_abort;
    // A VLD is legitimate only for our own read; a read orphaned by an abort is swallowed silently.
    assign w_spur     = I_BRAM_RD_VLD && !r_out && !r_stale;

    // The next read lands in the buffer after any capture this cycle; a buffer freed by the
    // final row handshake this cycle already counts as free, which is what removes bubbles.
    assign w_wr_tgt    = w_cap ? ~r_wr_sel : r_wr_sel;
    assign w_tgt_free  = !r_full[w_wr_tgt] || (w_tile_end && (r_rd_sel == w_wr_tgt));
    assign w_issue     = (r_state == S_RUN) && !w_abort && (!r_out || w_cap) && !r_stale
                         && (r_rd_cnt < (TW+1)'(TILES)) && w_tgt_free;
    assign w_issue_any = w_issue || (w_start && !r_stale);
    assign w_rd_idx    = w_start ? '0 : r_rd_cnt;

    always_comb begin
        w_full_nxt = r_full;
        if (w_tile_end) w_full_nxt[r_rd_sel] = 1'b0;
        if (w_cap)      w_full_nxt[r_wr_sel] = 1'b1;
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_full   <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_rd_cnt <= '0;
            r_tile   <= '0;
            r_row    <= '0;
            r_out    <= 1'b0;
            r_stale  <= 1'b0;
            r_err    <= 1'b0;
            r_abort  <= 1'b0;
            r_en     <= 1'b0;
            r_line   <= '0;
            r_col    <= '0;
        end else begin
            r_abort <= w_abort;
            r_en    <= w_issue_any;
            if (w_spur) r_err <= 1'b1;
            if (w_issue_any) begin
                r_line   <= w_rd_idx[TW-1:CW];
                r_col    <= w_rd_idx[CW-1:0];
                r_rd_cnt <= w_rd_idx + (TW+1)'(1);
            end else if (w_start) begin
                r_rd_cnt <= '0;
            end
            if (w_abort)          r_out <= 1'b0;
            else if (w_issue_any) r_out <= 1'b1;
            else if (w_cap)       r_out <= 1'b0;
            if (w_abort)                         r_stale <= r_out && !I_BRAM_RD_VLD;
            else if (I_BRAM_RD_VLD && r_stale)   r_stale <= 1'b0;
            if (w_start || w_abort) begin
                r_full   <= '0;
                r_wr_sel <= 1'b0;
                r_rd_sel <= 1'b0;
                r_tile   <= '0;
                r_row    <= '0;
            end else begin
                r_full <= w_full_nxt;
                if (w_cap) r_wr_sel <= ~r_wr_sel;
                if (w_acc) r_row <= r_row + RW'(1);
                if (w_tile_end) begin
                    r_tile   <= r_tile + TW'(1);
                    r_rd_sel <= ~r_rd_sel;
                end
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (w_cap) r_buf[r_wr_sel] <= I_BRAM_RD_MAT;
    end

    // Row 0 sits in the top slice of the tile word.
    assign w_slot         = RW'(TILE - 1) - r_row;
    assign O_TDATA        = w_tvalid ? r_buf[r_rd_sel][int'(w_slot)*OUT_W +: OUT_W] : '0;
    assign O_TVALID       = w_tvalid;
    assign O_TLAST        = w_tvalid && w_last;
    assign O_TILE_LINE    = r_tile[TW-1:CW];
    assign O_TILE_COL     = r_tile[CW-1:0];
    assign O_ROW          = r_row;
    assign O_RD_BRAM_EN   = r_en;
    assign O_RD_BRAM_LINE = r_line;
    assign O_RD_BRAM_COL  = r_col;
    assign O_BUSY         = (r_state == S_RUN);
    assign O_DONE         = (r_state == S_DONE);
    assign O_ABORT        = r_abort;
    assign O_ERR          = r_err;
endmodule
